// File: rtl/serial_bus_master_p_if.sv
// Command, arbitration, serial-link and response signals of serial_bus_master_p.
// The master modport is the controller's view; the slave modport is the user/slave side.
interface serial_bus_master_p_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_read;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              bus_ready;
  logic              bus_req;
  logic              addr_tx;
  logic              data_tx;
  logic              valid;
  logic              valid_s;
  logic              data_rx;
  logic              slave_valid;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, bus_ready, data_rx, slave_valid,
    output cmd_ready, bus_req, addr_tx, data_tx, valid, valid_s, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, bus_ready, data_rx, slave_valid,
    input  cmd_ready, bus_req, addr_tx, data_tx, valid, valid_s, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/serial_bus_master_p.sv
// Serial bus master: accepts one command, arbitrates for the bus, shifts the address (and
// write data) out MSB first, optionally collects serial read data, then reports a response.
module serial_bus_master_p #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 8,  // 1 <= DATA_W <= ADDR_W
  parameter int unsigned TIMEOUT = 255 // >= 1
) (
  input logic               clock,
  input logic               reset_n,
  serial_bus_master_p_if.master bus
);

  localparam int unsigned M1     = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CntMax = (M1 > TIMEOUT) ? M1 : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StReq, StStart, StShift, StRwait, StRdata, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Write data right-aligned in an address-wide register so the leading zeros fall out
  logic [ADDR_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              bus_req_q, bus_req_d;
  logic              addr_tx_q, addr_tx_d;
  logic              data_tx_q, data_tx_d;
  logic              valid_q, valid_d;
  logic              valid_s_q, valid_s_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      shreg_q     <= '0;
      cmd_ready_q <= 1'b0;
      bus_req_q   <= 1'b0;
      addr_tx_q   <= 1'b0;
      data_tx_q   <= 1'b0;
      valid_q     <= 1'b0;
      valid_s_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      shreg_q     <= shreg_d;
      cmd_ready_q <= cmd_ready_d;
      bus_req_q   <= bus_req_d;
      addr_tx_q   <= addr_tx_d;
      data_tx_q   <= data_tx_d;
      valid_q     <= valid_d;
      valid_s_q   <= valid_s_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_d      = read_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    shreg_d     = shreg_q;
    cmd_ready_d = 1'b0;
    bus_req_d   = bus_req_q;
    addr_tx_d   = 1'b0;
    data_tx_d   = 1'b0;
    valid_d     = 1'b0;
    valid_s_d   = valid_s_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          read_d    = bus.cmd_read;
          addr_d    = bus.cmd_addr;
          wd_d      = bus.cmd_read ? '0 : ADDR_W'(bus.cmd_wdata);
          bus_req_d = 1'b1;
          state_d   = StReq;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      StReq: begin
        if (bus.bus_ready) begin
          valid_d   = 1'b1;
          valid_s_d = 1'b1;
          state_d   = StStart;
        end
      end
      StStart: begin
        addr_tx_d = addr_q[ADDR_W-1];
        data_tx_d = wd_q[ADDR_W-1];
        addr_d    = addr_q << 1;
        wd_d      = wd_q << 1;
        cnt_d     = '0;
        state_d   = StShift;
      end
      StShift: begin
        if (cnt_q == CntW'(ADDR_W - 1)) begin
          valid_s_d = 1'b0;
          cnt_d     = '0;
          if (read_q) begin
            state_d = StRwait;
          end else begin
            bus_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            state_d     = StDone;
          end
        end else begin
          addr_tx_d = addr_q[ADDR_W-1];
          data_tx_d = wd_q[ADDR_W-1];
          addr_d    = addr_q << 1;
          wd_d      = wd_q << 1;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      StRwait: begin
        // slave_valid takes priority over a timeout on the same edge
        if (bus.slave_valid) begin
          cnt_d   = '0;
          state_d = StRdata;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdata: begin
        if (cnt_q == CntW'(DATA_W)) begin
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = shreg_q;
          state_d     = StDone;
        end else begin
          shreg_d = DATA_W'({shreg_q, bus.data_rx});
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StDone: begin
        cmd_ready_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.addr_tx   = addr_tx_q;
  assign bus.data_tx   = data_tx_q;
  assign bus.valid     = valid_q;
  assign bus.valid_s   = valid_s_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_serial_bus_master_p.sv
// Bench for serial_bus_master_p: a 14/8/255 instance and a 16/16/4 instance share stimulus;
// sel picks which one receives commands and which one is observed.
module tb_serial_bus_master_p;

  logic        clock;
  logic        reset_n;
  logic        sel;
  logic        cmd_valid;
  logic        cmd_read;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        bus_ready;
  logic        data_rx;
  logic        slave_valid;
  logic [23:0] obs;
  logic [15:0] last_rd [2];
  int          errors;
  int          checks;

  typedef struct {
    bit          is_b;
    bit          rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          req_delay;
    int          sv_delay;
    logic [15:0] rx;
    logic [15:0] exp_rdata;
    bit          exp_err;
  } txn_t;

  serial_bus_master_p_if #(.ADDR_W(14), .DATA_W(8))  if_a ();
  serial_bus_master_p_if #(.ADDR_W(16), .DATA_W(16)) if_b ();

  assign if_a.cmd_valid   = cmd_valid & ~sel;
  assign if_a.cmd_read    = cmd_read;
  assign if_a.cmd_addr    = cmd_addr[13:0];
  assign if_a.cmd_wdata   = cmd_wdata[7:0];
  assign if_a.bus_ready   = bus_ready;
  assign if_a.data_rx     = data_rx;
  assign if_a.slave_valid = slave_valid;
  assign if_b.cmd_valid   = cmd_valid & sel;
  assign if_b.cmd_read    = cmd_read;
  assign if_b.cmd_addr    = cmd_addr;
  assign if_b.cmd_wdata   = cmd_wdata;
  assign if_b.bus_ready   = bus_ready;
  assign if_b.data_rx     = data_rx;
  assign if_b.slave_valid = slave_valid;

  serial_bus_master_p #(.ADDR_W(14), .DATA_W(8), .TIMEOUT(255)) dut_a (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (if_a)
  );

  serial_bus_master_p #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut_b (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (if_b)
  );

  assign obs = sel ?
    {if_b.cmd_ready, if_b.bus_req, if_b.addr_tx, if_b.data_tx, if_b.valid, if_b.valid_s,
     if_b.rsp_valid, if_b.rsp_err, if_b.rsp_rdata} :
    {if_a.cmd_ready, if_a.bus_req, if_a.addr_tx, if_a.data_tx, if_a.valid, if_a.valid_s,
     if_a.rsp_valid, if_a.rsp_err, 8'h00, if_a.rsp_rdata};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [23:0] ex(input logic cr, input logic br, input logic at,
                                     input logic dt, input logic v, input logic vs,
                                     input logic rv, input logic re, input logic [15:0] rd);
    return {cr, br, at, dt, v, vs, rv, re, rd};
  endfunction

  // Response a command should produce, from the observable rules only
  function automatic txn_t ref_model(input txn_t t);
    txn_t r;
    int   to;
    r  = t;
    to = t.is_b ? 4 : 255;
    if (!t.rd) begin
      r.exp_rdata = 16'h0;
      r.exp_err   = 1'b0;
    end else if (t.sv_delay >= to) begin
      r.exp_rdata = 16'h0;
      r.exp_err   = 1'b1;
    end else begin
      r.exp_rdata = t.is_b ? t.rx : {8'h00, t.rx[7:0]};
      r.exp_err   = 1'b0;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (sel=%0d t=%0t)", name, obs, want, sel, $time);
    end
  endtask

  // Inputs that the DUT must ignore in the current state
  task automatic noise();
    cmd_valid = 1'($urandom);
    cmd_read  = 1'($urandom);
    cmd_addr  = 16'($urandom);
    cmd_wdata = 16'($urandom);
    bus_ready = 1'($urandom);
    data_rx   = 1'($urandom);
  endtask

  // Drives one command end to end; abort_k >= 0 returns right after shift edge abort_k
  task automatic run_txn(input txn_t t, input int abort_k);
    int          aw;
    int          dw;
    int          to;
    logic [15:0] hold;
    logic        a_bit;
    logic        d_bit;
    aw   = t.is_b ? 16 : 14;
    dw   = t.is_b ? 16 : 8;
    to   = t.is_b ? 4 : 255;
    hold = last_rd[t.is_b];
    sel  = t.is_b;
    cmd_read    = t.rd;
    cmd_addr    = t.addr;
    cmd_wdata   = t.wdata;
    cmd_valid   = 1'b1;
    bus_ready   = 1'($urandom);
    slave_valid = 1'b0;
    step();
    check("accept", ex(0, 1, 0, 0, 0, 0, 0, 0, hold));
    for (int i = 0; i < t.req_delay; i++) begin
      noise();
      bus_ready = 1'b0;
      step();
      check("req_wait", ex(0, 1, 0, 0, 0, 0, 0, 0, hold));
    end
    noise();
    bus_ready = 1'b1;
    step();
    check("start", ex(0, 1, 0, 0, 1, 1, 0, 0, hold));
    for (int k = 0; k < aw; k++) begin
      noise();
      a_bit = t.addr[aw-1-k];
      d_bit = (!t.rd && k >= aw - dw) ? t.wdata[aw-1-k] : 1'b0;
      step();
      check("shift", ex(0, 1, a_bit, d_bit, 0, 1, 0, 0, hold));
      if (k == abort_k) return;
    end
    noise();
    step();
    if (!t.rd) begin
      check("done_wr", ex(0, 0, 0, 0, 0, 0, 1, t.exp_err, t.exp_rdata));
    end else begin
      check("rwait_enter", ex(0, 1, 0, 0, 0, 0, 0, 0, hold));
      if (t.sv_delay < to) begin
        for (int c = 0; c < t.sv_delay; c++) begin
          noise();
          slave_valid = 1'b0;
          step();
          check("rwait", ex(0, 1, 0, 0, 0, 0, 0, 0, hold));
        end
        noise();
        slave_valid = 1'b1;
        step();
        check("rdata_enter", ex(0, 1, 0, 0, 0, 0, 0, 0, hold));
        for (int i = 0; i < dw; i++) begin
          noise();
          slave_valid = 1'($urandom);
          data_rx     = t.rx[dw-1-i];
          step();
          check("rdata", ex(0, 1, 0, 0, 0, 0, 0, 0, hold));
        end
        noise();
        slave_valid = 1'b0;
        step();
      end else begin
        for (int c = 0; c < to - 1; c++) begin
          noise();
          slave_valid = 1'b0;
          step();
          check("rwait", ex(0, 1, 0, 0, 0, 0, 0, 0, hold));
        end
        noise();
        slave_valid = 1'b0;
        step();
      end
      check("done_rd", ex(0, 0, 0, 0, 0, 0, 1, t.exp_err, t.exp_rdata));
    end
    last_rd[t.is_b] = t.exp_rdata;
    noise();
    step();
    check("idle", ex(1, 0, 0, 0, 0, 0, 0, 0, last_rd[t.is_b]));
    cmd_valid   = 1'b0;
    slave_valid = 1'b0;
  endtask

  txn_t tbl [9];
  txn_t rt;

  initial begin
    errors = 0;
    checks = 0;
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    sel = 1'b0;
    cmd_valid = 1'b0;
    cmd_read = 1'b0;
    cmd_addr = 16'h0;
    cmd_wdata = 16'h0;
    bus_ready = 1'b0;
    data_rx = 1'b0;
    slave_valid = 1'b0;
    reset_n = 1'b0;

    //         is_b  rd    addr      wdata     req sv   rx        exp_rd    err
    tbl[0] = '{1'b0, 1'b0, 16'h2A5C, 16'h00C3, 0,  0,   16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h0001, 16'h0000, 0,  5,   16'h00B2, 16'h00B2, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 16'h1FFF, 16'h005A, 10, 0,   16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 16'h1234, 16'h0000, 0,  99,  16'hFFFF, 16'h0000, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 16'hABCD, 16'hFFFF, 0,  0,   16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'h8001, 16'h0000, 2,  3,   16'h1234, 16'h1234, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'h3FFF, 16'h0000, 0,  254, 16'h005A, 16'h005A, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 16'h2000, 16'h0000, 1,  255, 16'h00FF, 16'h0000, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 16'h0F0F, 16'h0000, 0,  0,   16'hC3A5, 16'hC3A5, 1'b0};

    #3;
    check("reset_a", 24'h0);
    sel = 1'b1;
    #1;
    check("reset_b", 24'h0);
    sel = 1'b0;
    step();
    step();
    check("reset_held", 24'h0);
    reset_n = 1'b1;
    #1;
    check("release_pre_edge", 24'h0);
    step();
    check("ready_a", ex(1, 0, 0, 0, 0, 0, 0, 0, 16'h0));
    sel = 1'b1;
    #1;
    check("ready_b", ex(1, 0, 0, 0, 0, 0, 0, 0, 16'h0));

    foreach (tbl[i]) run_txn(tbl[i], -1);

    // Reset pulsed mid-frame at shift edge k=5
    rt = '{1'b0, 1'b0, 16'h15A5, 16'h0096, 0, 0, 16'h0, 16'h0, 1'b0};
    run_txn(rt, 5);
    reset_n = 1'b0;
    #1;
    check("abort_async", 24'h0);
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    cmd_valid = 1'b0;
    step();
    check("abort_held", 24'h0);
    reset_n = 1'b1;
    step();
    check("abort_ready", ex(1, 0, 0, 0, 0, 0, 0, 0, 16'h0));
    step();
    check("abort_no_rsp", ex(1, 0, 0, 0, 0, 0, 0, 0, 16'h0));

    for (int n = 0; n < 40; n++) begin
      rt.is_b      = 1'($urandom);
      rt.rd        = 1'($urandom);
      rt.addr      = 16'($urandom);
      rt.wdata     = 16'($urandom);
      rt.req_delay = int'($urandom_range(0, 3));
      rt.sv_delay  = rt.is_b ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 8));
      rt.rx        = 16'($urandom);
      if (!rt.is_b) begin
        rt.addr[15:14] = 2'b00;
        rt.wdata[15:8] = 8'h00;
      end
      run_txn(ref_model(rt), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_bus_master_p.md
SERIAL_BUS_MASTER_P -- requirements
Module: serial_bus_master_p

Interface
REQ-001 Parameters SHALL be:
  ADDR_W   14   address bits per frame
  DATA_W   8    data bits per frame; must satisfy 1 <= DATA_W <= ADDR_W
  TIMEOUT  255  max RWAIT cycles before error; >= 1
REQ-002 Ports SHALL be:
  clock        in   1       single clock, rising edge
  reset_n      in   1       asynchronous, active-low reset
  cmd_valid    in   1       user command present
  cmd_ready    out  1       master can accept a command
  cmd_read     in   1       1 = read, 0 = write
  cmd_addr     in   ADDR_W  target address
  cmd_wdata    in   DATA_W  write data
  bus_ready    in   1       arbiter grant
  bus_req      out  1       bus request
  addr_tx      out  1       serial address, MSB first
  data_tx      out  1       serial write data, MSB first
  valid        out  1       one-cycle frame-start strobe
  valid_s      out  1       slave-select window
  data_rx      in   1       serial read data from the slave
  slave_valid  in   1       slave read data follows
  rsp_valid    out  1       one-cycle completion strobe
  rsp_rdata    out  DATA_W  read result
  rsp_err      out  1       read timed out
REQ-003 Every output SHALL be a flop output.

Function
REQ-004 The FSM SHALL have states IDLE, REQ, START, SHIFT, RWAIT, RDATA and DONE; outputs SHALL change on the edge that enters a state.
REQ-005 IDLE: cmd_ready=1; cmd_valid&cmd_ready SHALL latch cmd_read/addr/wdata, set bus_req=1 and cmd_ready=0, and go to REQ.
REQ-006 cmd_ready SHALL be 0 in every state except IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-007 REQ: the FSM SHALL stay in REQ until bus_ready=1 is sampled, then go to START with valid=1 and valid_s=1.
REQ-008 START lasts one cycle; the next edge SHALL enter SHIFT with valid=0 and counter k=0.
REQ-009 SHIFT edge k (k=0..ADDR_W-1) SHALL drive addr_tx=addr[ADDR_W-1-k].
REQ-010 On a write, for k >= ADDR_W-DATA_W, data_tx SHALL be wdata[ADDR_W-1-k]; data_tx SHALL be 0 otherwise.
REQ-011 After the last address bit, the next edge SHALL set valid_s=0 and addr_tx=data_tx=0, entering DONE on a write and RWAIT on a read.
REQ-012 RWAIT SHALL count cycles. slave_valid=1 SHALL enter RDATA with j=0.
REQ-013 If TIMEOUT cycles elapse in RWAIT without slave_valid, the FSM SHALL enter DONE with rsp_err=1 and rsp_rdata=0.
REQ-014 If slave_valid=1 arrives on the timeout edge, slave_valid SHALL win (no error).
REQ-015 RDATA SHALL sample data_rx on DATA_W consecutive edges, shifting in MSB first; the edge after the last sample SHALL enter DONE.
REQ-016 DONE (one cycle): bus_req=0 and rsp_valid=1; rsp_rdata holds the read data, or 0 for a write; rsp_err as set. The next edge SHALL return to IDLE with rsp_valid=0 and rsp_err=0.
REQ-017 Once START is entered, bus_ready is ignored until DONE; bus_req SHALL stay 1 from accept through the DONE-entering edge.
REQ-018 rsp_rdata SHALL hold its value until the next DONE.
REQ-019 The bit and timeout counters SHALL be wide enough for max(ADDR_W, DATA_W, TIMEOUT) with no wrap-around.

Reset
REQ-020 reset_n=0 SHALL immediately force state=IDLE and all outputs and counters to 0, including cmd_ready=0 and rsp_rdata=0.
REQ-021 cmd_ready SHALL rise on the first edge after reset_n deasserts.
REQ-022 Reset mid-frame SHALL abort the transfer with no rsp_valid.

Verification
REQ-023 Write, defaults: addr=14'h2A5C, wdata=8'hC3, bus_ready=1 -> valid high 1 cycle; addr_tx serialises 10101001011100; data_tx is 0 for 6 bits, then 11000011; rsp_valid at accept+16 edges; rsp_err=0.
REQ-024 Read: addr=14'h0001; slave_valid after 5 RWAIT cycles; data_rx=10110010 -> rsp_rdata=8'hB2, rsp_err=0.
REQ-025 Read with slave_valid held 0 and TIMEOUT=4 -> DONE after 4 RWAIT cycles with rsp_err=1, rsp_rdata=0, then bus_req=0.
REQ-026 bus_ready held 0 for 10 cycles after accept -> FSM stays in REQ with bus_req=1 and valid=0, and proceeds when bus_ready=1; cmd_valid pulses meanwhile are ignored.
REQ-027 reset_n pulsed low in SHIFT k=5 -> all outputs 0 at once; cmd_ready=1 one edge after release; no rsp_valid.
REQ-028 ADDR_W=16, DATA_W=16 write with wdata=16'hFFFF -> data_tx=1 for all 16 SHIFT cycles.
